// File: rtl/mock_uart_tx.sv
// mock_uart_tx -- simulation UART transmitter.
// Bytes pushed over a valid/ready interface are queued in an internal FIFO
// and serialised on tx_sig as START / DATA (LSB first) / optional PARITY /
// STOP frames. Frames are sent back-to-back while the FIFO holds data.
// Optional feature: define MOCK_UART_TX_ERR_INJ_EN to add the err_inj input,
// which corrupts the parity bit (or the first stop bit when there is no
// parity) of the frame popped while it is high.
`timescale 1ns/1ps

`ifndef CLK_FREQ
`define CLK_FREQ 100_000_000
`endif

module mock_uart_tx #(
    parameter int BaudRate     = 9600,
    parameter int ParityBit    = 0,
    parameter int DataBitsSize = 8,
    parameter int StopBitsSize = 1,
    parameter int BufferSize   = 128,
    parameter int ClockFreqHz  = `CLK_FREQ
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        wr_valid,
    input  logic [DataBitsSize-1:0]     wr_data,
    output logic                        wr_ready,
    output logic                        tx_sig,
    output logic                        busy,
    output logic [$clog2(BufferSize):0] level
`ifdef MOCK_UART_TX_ERR_INJ_EN
    ,
    input  logic                        err_inj
`endif
);

    localparam int ClksPerBit = ClockFreqHz / BaudRate;
    localparam int AddrW      = $clog2(BufferSize);
    localparam int LvlW       = AddrW + 1;
    localparam int CntW       = (ClksPerBit >= 2) ? $clog2(ClksPerBit) : 1;

    // Elaboration-time parameter legality
    if (ClksPerBit < 2) begin : g_bad_clks
        $error("mock_uart_tx: ClksPerBit=%0d, must be >= 2", ClksPerBit);
    end
    if (ParityBit < 0 || ParityBit > 2) begin : g_bad_parity
        $error("mock_uart_tx: ParityBit=%0d, must be 0, 1 or 2", ParityBit);
    end
    if (DataBitsSize < 5 || DataBitsSize > 9) begin : g_bad_data
        $error("mock_uart_tx: DataBitsSize=%0d, must be 5..9", DataBitsSize);
    end
    if (StopBitsSize < 1 || StopBitsSize > 2) begin : g_bad_stop
        $error("mock_uart_tx: StopBitsSize=%0d, must be 1..2", StopBitsSize);
    end
    if (BufferSize < 2 || (BufferSize & (BufferSize - 1)) != 0) begin : g_bad_buf
        $error("mock_uart_tx: BufferSize=%0d, must be a power of two >= 2", BufferSize);
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t                  state_q;
    logic [CntW-1:0]         baud_q;
    logic [3:0]              bit_q;
    logic [DataBitsSize-1:0] shift_q;
    logic                    par_q;
    logic                    err_q;
    logic                    tx_q;

    logic [DataBitsSize-1:0] mem_q [BufferSize];
    logic [AddrW-1:0]        wr_ptr_q;
    logic [AddrW-1:0]        rd_ptr_q;
    logic [LvlW-1:0]         level_q;

    logic                    push;
    logic                    pop;
    logic                    bit_end;
    logic                    frame_end;
    logic                    par_d;
    logic                    err_d;
    logic [DataBitsSize-1:0] head;

`ifdef MOCK_UART_TX_ERR_INJ_EN
    assign err_d = err_inj;
`else
    assign err_d = 1'b0;
`endif

    assign head     = mem_q[rd_ptr_q];
    assign wr_ready = (level_q < LvlW'(BufferSize));
    assign tx_sig   = tx_q;
    assign busy     = (state_q != S_IDLE);
    assign level    = level_q;

    // Push/pop decisions; a pop also fires on the last stop cycle so frames abut
    always_comb begin
        bit_end   = (baud_q == CntW'(ClksPerBit - 1));
        frame_end = (state_q == S_STOP) && bit_end && (bit_q == 4'(StopBitsSize - 1));
        push      = wr_valid && wr_ready;
        pop       = (level_q != '0) && ((state_q == S_IDLE) || frame_end);
        par_d     = (ParityBit == 2) ? (^head) : ~(^head);
    end

    // FIFO storage array (data only, never reset)
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally on a power-of-two depth
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            if (push && !pop) begin
                level_q <= level_q + 1'b1;
            end else if (pop && !push) begin
                level_q <= level_q - 1'b1;
            end
        end
    end

    // Frame FSM with registered serial output; tx_q always carries the bit of the state being entered
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            par_q   <= 1'b0;
            err_q   <= 1'b0;
            tx_q    <= 1'b1;
        end else if (pop) begin
            state_q <= S_START;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= head;
            par_q   <= par_d;
            err_q   <= err_d;
            tx_q    <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    baud_q <= '0;
                    tx_q   <= 1'b1;
                end
                S_START: begin
                    if (bit_end) begin
                        state_q <= S_DATA;
                        baud_q  <= '0;
                        bit_q   <= '0;
                        tx_q    <= shift_q[0];
                    end else begin
                        baud_q <= baud_q + 1'b1;
                    end
                end
                S_DATA: begin
                    if (bit_end) begin
                        baud_q <= '0;
                        if (bit_q == 4'(DataBitsSize - 1)) begin
                            bit_q <= '0;
                            if (ParityBit != 0) begin
                                state_q <= S_PARITY;
                                tx_q    <= par_q ^ err_q;
                            end else begin
                                state_q <= S_STOP;
                                tx_q    <= ~err_q;
                            end
                        end else begin
                            bit_q   <= bit_q + 1'b1;
                            shift_q <= shift_q >> 1;
                            tx_q    <= shift_q[1];
                        end
                    end else begin
                        baud_q <= baud_q + 1'b1;
                    end
                end
                S_PARITY: begin
                    if (bit_end) begin
                        state_q <= S_STOP;
                        baud_q  <= '0;
                        bit_q   <= '0;
                        tx_q    <= 1'b1;
                    end else begin
                        baud_q <= baud_q + 1'b1;
                    end
                end
                S_STOP: begin
                    if (bit_end) begin
                        baud_q <= '0;
                        tx_q   <= 1'b1;
                        if (bit_q == 4'(StopBitsSize - 1)) begin
                            state_q <= S_IDLE;
                            bit_q   <= '0;
                        end else begin
                            bit_q <= bit_q + 1'b1;
                        end
                    end else begin
                        baud_q <= baud_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    baud_q  <= '0;
                    tx_q    <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mock_uart_tx.sv
// Bench for mock_uart_tx: an 8N1 instance (depth 4) checked every cycle
// against a frame-level model, plus 8E1 / 8O1 instances pinned by literals.
`timescale 1ns/1ps

module tb_mock_uart_tx;

    localparam int C  = 10;   // clocks per bit
    localparam int FL = 10;   // bits per 8N1 frame
    localparam int FC = FL * C;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic wr_valid = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic wr_valid_p = 1'b0;
    logic [7:0] wr_data_p = 8'h00;
    logic err_inj = 1'b0;
    logic err_off = 1'b0;

    logic ready_m, tx_m, busy_m;
    logic [2:0] level_m;
    logic ready_e, tx_e, busy_e;
    logic [3:0] level_e;
    logic ready_o, tx_o, busy_o;
    logic [3:0] level_o;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mock_uart_tx #(.BaudRate(100_000), .ParityBit(0), .DataBitsSize(8), .StopBitsSize(1),
                   .BufferSize(4), .ClockFreqHz(1_000_000)) u_n81 (
        .clk(clk), .rst_n(rst_n), .wr_valid(wr_valid), .wr_data(wr_data),
        .wr_ready(ready_m), .tx_sig(tx_m), .busy(busy_m), .level(level_m)
`ifdef MOCK_UART_TX_ERR_INJ_EN
        , .err_inj(err_inj)
`endif
    );

    mock_uart_tx #(.BaudRate(100_000), .ParityBit(2), .DataBitsSize(8), .StopBitsSize(1),
                   .BufferSize(8), .ClockFreqHz(1_000_000)) u_e81 (
        .clk(clk), .rst_n(rst_n), .wr_valid(wr_valid_p), .wr_data(wr_data_p),
        .wr_ready(ready_e), .tx_sig(tx_e), .busy(busy_e), .level(level_e)
`ifdef MOCK_UART_TX_ERR_INJ_EN
        , .err_inj(err_off)
`endif
    );

    mock_uart_tx #(.BaudRate(100_000), .ParityBit(1), .DataBitsSize(8), .StopBitsSize(1),
                   .BufferSize(8), .ClockFreqHz(1_000_000)) u_o81 (
        .clk(clk), .rst_n(rst_n), .wr_valid(wr_valid_p), .wr_data(wr_data_p),
        .wr_ready(ready_o), .tx_sig(tx_o), .busy(busy_o), .level(level_o)
`ifdef MOCK_UART_TX_ERR_INJ_EN
        , .err_inj(err_off)
`endif
    );

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- frame-level model of the 8N1 instance ----------------
    logic [7:0] mq[$];
    logic       m_act = 1'b0;
    int         m_t = 0;
    logic [7:0] m_d = 8'h00;
    logic       m_e = 1'b0;
    logic       m_acc, m_pop;

    // Line value t cycles into a frame carrying byte d (e = corrupted stop)
    function automatic logic exp_bit(input logic [7:0] d, input int t, input logic e);
        int b;
        b = t / C;
        if (b == 0) return 1'b0;
        if (b <= 8) return d[b-1];
        if (b == 9) return ~e;
        return 1'b1;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mq.delete();
            m_act = 1'b0;
            m_t   = 0;
            m_e   = 1'b0;
        end else begin
            m_acc = wr_valid && (mq.size() < 4);
            m_pop = (mq.size() > 0) && (!m_act || m_t == FC - 1);
            if (m_pop) begin
                m_d   = mq.pop_front();
                m_e   = err_inj;
                m_t   = 0;
                m_act = 1'b1;
            end else if (m_act) begin
                if (m_t == FC - 1) m_act = 1'b0;
                else m_t++;
            end
            if (m_acc) mq.push_back(wr_data);
        end
    end

    always @(negedge clk) begin
        logic [5:0] exp_v;
        logic [5:0] act_v;
        exp_v = {(m_act ? exp_bit(m_d, m_t, m_e) : 1'b1), m_act, (mq.size() < 4), 3'(mq.size())};
        act_v = {tx_m, busy_m, ready_m, level_m};
        check("cycle{tx,busy,ready,level}", 32'(act_v), 32'(exp_v));
    end

    // ---------------- directed stimulus ----------------
    int   k, n, refused;
    logic acc;
    logic [7:0] got;

    // Wait (bounded) for the main line to drop into a start bit
    task automatic wait_fall_m(input string nm);
        int w;
        w = 0;
        @(negedge clk);
        while (tx_m !== 1'b0 && w < 200) begin
            @(negedge clk);
            w++;
        end
        check(nm, 32'(w < 200), 32'd1);
    endtask

    initial begin
        // Reset
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_tx", 32'(tx_m), 32'd1);
        check("rst_ready", 32'(ready_m), 32'd1);
        check("rst_busy", 32'(busy_m), 32'd0);
        check("rst_level", 32'(level_m), 32'd0);
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (50) @(negedge clk);
        check("idle50_tx", 32'(tx_m), 32'd1);

        // 8N1, byte A5
        @(posedge clk); #1 wr_valid = 1'b1; wr_data = 8'hA5;
        @(posedge clk); #1 wr_valid = 1'b0;
        wait_fall_m("a5_start");
        k = 0; got = 8'h00;
        while (busy_m && k < 1000) begin
            if (k == 5) check("a5_startbit", 32'(tx_m), 32'd0);
            if (k >= 15 && k <= 85 && (k - 15) % 10 == 0) got[(k - 15) / 10] = tx_m;
            if (k == 95) check("a5_stopbit", 32'(tx_m), 32'd1);
            k++;
            @(negedge clk);
        end
        check("a5_data", 32'(got), 32'h0000_00A5);
        check("a5_busy_len", 32'(k), 32'd100);

        // Parity: 8'h07 -> even parity 1, odd parity 0, frame 110 clk
        @(posedge clk); #1 wr_valid_p = 1'b1; wr_data_p = 8'h07;
        @(posedge clk); #1 wr_valid_p = 1'b0;
        n = 0;
        @(negedge clk);
        while (tx_e !== 1'b0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("par_start", 32'(n < 200), 32'd1);
        k = 0;
        while (busy_e && k < 1000) begin
            if (k == 95) begin
                check("par_even", 32'(tx_e), 32'd1);
                check("par_odd", 32'(tx_o), 32'd0);
            end
            if (k == 105) check("par_stop", 32'(tx_e), 32'd1);
            k++;
            @(negedge clk);
        end
        check("par_busy_len", 32'(k), 32'd110);
        check("par_odd_done", 32'(busy_o), 32'd0);

        // Full FIFO / back-to-back: six words on consecutive cycles into depth 4
        @(posedge clk); #1;
        refused = 0;
        n = 0;
        for (int i = 0; i < 6; i++) begin
            wr_valid = 1'b1;
            wr_data  = 8'(8'h11 * (i + 1));
            do begin
                @(negedge clk);
                acc = ready_m;
                if (!acc) refused++;
                @(posedge clk); #1;
                n++;
            end while (!acc && n < 500);
            if (i == 4) check("full_level", 32'(level_m), 32'd4);
        end
        wr_valid = 1'b0;
        check("full_refused", 32'(refused), 32'd97);
        k = 0;
        @(negedge clk);
        while (busy_m && k < 2000) begin
            k++;
            @(negedge clk);
        end
        check("b2b_busy_run", 32'(k), 32'd499);
        check("b2b_empty", 32'(level_m), 32'd0);

        // Reset during DATA bit 3
        @(posedge clk); #1 wr_valid = 1'b1; wr_data = 8'hA5;
        @(posedge clk); #1 wr_data = 8'h5A;
        @(posedge clk); #1 wr_valid = 1'b0;
        wait_fall_m("mid_start");
        repeat (45) @(negedge clk);
        check("mid_pre_tx", 32'(tx_m), 32'd0);
        check("mid_pre_level", 32'(level_m), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        check("mid_rst_tx", 32'(tx_m), 32'd1);
        check("mid_rst_level", 32'(level_m), 32'd0);
        check("mid_rst_busy", 32'(busy_m), 32'd0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (30) @(negedge clk);
        check("mid_after_tx", 32'(tx_m), 32'd1);

`ifdef MOCK_UART_TX_ERR_INJ_EN
        // Framing error injected on 8'h3C
        @(posedge clk); #1 wr_valid = 1'b1; wr_data = 8'h3C; err_inj = 1'b1;
        @(posedge clk); #1 wr_valid = 1'b0;
        wait_fall_m("err_start");
        err_inj = 1'b0;
        repeat (95) @(negedge clk);
        check("err_stopbit", 32'(tx_m), 32'd0);
        repeat (20) @(negedge clk);
        check("err_idle", 32'(tx_m), 32'd1);
`endif

        repeat (5) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d", n_err);
        $fatal(1, "watchdog");
    end

endmodule
